// File: rtl/fib_lookup.sv
// Forwarding-information-base lookup: hashes the destination MAC into a small
// direct-mapped table, produces a port mask, and learns the source MAC/port.
module fib_lookup #(
    parameter int num_ports = 4,
    parameter int port_sz   = 2,
    parameter int fib_asz   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    lpp_srdy,
    output logic                    lpp_drdy,
    input  logic [96+port_sz-1:0]   lpp_data,
    output logic                    ft_srdy,
    input  logic                    ft_drdy,
    output logic [num_ports-1:0]    ft_data,
    input  logic                    flush
);

    localparam int entries = 1 << fib_asz;
    localparam int slices  = (48 + fib_asz - 1) / fib_asz;
    localparam logic [num_ports-1:0] port_one = num_ports'(1);

    typedef enum logic [1:0] {IDLE, LOOKUP, LEARN, RESULT} state_t;

    typedef struct packed {
        logic               valid;
        logic [47:0]        mac;
        logic [port_sz-1:0] port;
    } entry_t;

    state_t                 state_q, state_d;
    logic [96+port_sz-1:0]  req_q;
    entry_t                 entry_q;
    logic [num_ports-1:0]   ft_data_q, mask_d;
    logic [entries-1:0]     valid_q;
    logic [47:0]            mac_mem  [entries];
    logic [port_sz-1:0]     port_mem [entries];

    logic [47:0]            src_mac, dst_mac;
    logic [port_sz-1:0]     src_port;
    logic [fib_asz-1:0]     src_idx, dst_idx;
    logic                   learn_we;
    logic                   hit;
    logic [num_ports-1:0]   flood;

    // Shifting right feeds zeros into the top slice, giving the zero-extension.
    function automatic logic [fib_asz-1:0] fib_hash(input logic [47:0] mac);
        logic [fib_asz-1:0] h;
        h = '0;
        for (int s = 0; s < slices; s++) begin
            h = h ^ fib_asz'(mac >> (s * fib_asz));
        end
        return h;
    endfunction

    assign src_mac  = req_q[47:0];
    assign dst_mac  = req_q[95:48];
    assign src_port = req_q[96+port_sz-1:96];
    assign src_idx  = fib_hash(src_mac);
    assign dst_idx  = fib_hash(dst_mac);
    assign ft_data  = ft_data_q;

    // Multicast sources are never learned; a coincident flush discards the write.
    assign learn_we = (state_q == LEARN) && !src_mac[40] && !flush;

    always_comb begin
        state_d  = state_q;
        lpp_drdy = 1'b0;
        ft_srdy  = 1'b0;
        unique case (state_q)
            IDLE: begin
                lpp_drdy = 1'b1;
                if (lpp_srdy) state_d = LOOKUP;
            end
            LOOKUP: state_d = LEARN;
            LEARN:  state_d = RESULT;
            RESULT: begin
                ft_srdy = 1'b1;
                if (ft_drdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range port numbers shift the one off the top: no bit cleared / no bit set.
    always_comb begin
        flood  = ~(port_one << src_port);
        hit    = entry_q.valid && (entry_q.mac == dst_mac);
        mask_d = flood;
        if (dst_mac[40])
            mask_d = flood;
        else if (hit && (entry_q.port == src_port))
            mask_d = '0;
        else if (hit)
            mask_d = port_one << entry_q.port;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            entry_q   <= '0;
            ft_data_q <= '0;
            valid_q   <= '0;
        end else begin
            state_q <= state_d;
            if (lpp_srdy && lpp_drdy)
                req_q <= lpp_data;
            if (state_q == LOOKUP)
                entry_q <= {valid_q[dst_idx], mac_mem[dst_idx], port_mem[dst_idx]};
            if (state_q == LEARN)
                ft_data_q <= mask_d;
            if (flush)
                valid_q <= '0;
            else if (learn_we)
                valid_q[src_idx] <= 1'b1;
        end
    end

    // NOTE: table payload has no reset; the valid bits alone decide whether it is used.
    always_ff @(posedge clk) begin
        if (learn_we) begin
            mac_mem[src_idx]  <= src_mac;
            port_mem[src_idx] <= src_port;
        end
    end

endmodule

// File: tb/tb_fib_lookup.sv
// Scoreboard bench for fib_lookup: directed learning/filter/flush/reset cases
// followed by randomized requests against a reference table model.
module tb_fib_lookup;

    localparam int NP = 4;
    localparam int PS = 2;
    localparam int AS = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              lpp_srdy;
    logic              lpp_drdy;
    logic [96+PS-1:0]  lpp_data;
    logic              ft_srdy;
    logic              ft_drdy;
    logic [NP-1:0]     ft_data;
    logic              flush;

    int total = 0;
    int bad   = 0;

    logic [NP-1:0] exp_q[$];

    bit            m_valid [16];
    logic [47:0]   m_mac   [16];
    logic [PS-1:0] m_port  [16];

    fib_lookup #(.num_ports(NP), .port_sz(PS), .fib_asz(AS)) dut (
        .clk      (clk),
        .reset    (reset),
        .lpp_srdy (lpp_srdy),
        .lpp_drdy (lpp_drdy),
        .lpp_data (lpp_data),
        .ft_srdy  (ft_srdy),
        .ft_drdy  (ft_drdy),
        .ft_data  (ft_data),
        .flush    (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_hash(input logic [47:0] mac);
        logic [3:0] h;
        h = 4'h0;
        for (int s = 0; s < 12; s++) h = h ^ mac[s*4 +: 4];
        return h;
    endfunction

    function automatic logic [NP-1:0] ref_mask(input logic [47:0] dst, input logic [PS-1:0] sp);
        logic [NP-1:0] fl;
        logic [3:0]    h;
        fl     = 4'hF;
        fl[sp] = 1'b0;
        if (dst[40]) return fl;
        h = ref_hash(dst);
        if (m_valid[h] && m_mac[h] == dst) begin
            if (m_port[h] == sp) return 4'b0000;
            return 4'b0001 << m_port[h];
        end
        return fl;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_learn(input logic [47:0] src, input logic [PS-1:0] sp);
        logic [3:0] h;
        if (!src[40]) begin
            h          = ref_hash(src);
            m_valid[h] = 1'b1;
            m_mac[h]   = src;
            m_port[h]  = sp;
        end
    endtask

    task automatic send(input string tag, input logic [47:0] src, input logic [47:0] dst,
                        input logic [PS-1:0] sp, input logic [NP-1:0] exp,
                        input int hold, input bit flush_at_learn);
        int            n;
        logic [NP-1:0] held;
        @(negedge clk);
        lpp_data = {sp, dst, src};
        lpp_srdy = 1'b1;
        n = 0;
        while (!lpp_drdy && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!lpp_drdy) begin
            check({tag, "/accept_timeout"}, 64'(lpp_drdy), 64'd1);
            lpp_srdy = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        if (flush_at_learn) model_clear();
        else                model_learn(src, sp);
        @(posedge clk);
        #1;
        lpp_srdy = 1'b0;
        lpp_data = '0;
        @(negedge clk);
        check({tag, "/srdy_c1"}, 64'(ft_srdy), 64'd0);
        check({tag, "/drdy_c1"}, 64'(lpp_drdy), 64'd0);
        @(negedge clk);
        check({tag, "/srdy_c2"}, 64'(ft_srdy), 64'd0);
        if (flush_at_learn) flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check({tag, "/srdy_c3"}, 64'(ft_srdy), 64'd1);
        held = ft_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "/hold_srdy"}, 64'(ft_srdy), 64'd1);
            check({tag, "/hold_data"}, 64'(ft_data), 64'(held));
            check({tag, "/hold_drdy"}, 64'(lpp_drdy), 64'd0);
        end
        ft_drdy = 1'b1;
        if (exp_q.size() > 0) check({tag, "/mask"}, 64'(ft_data), 64'(exp_q.pop_front()));
        @(posedge clk);
        #1;
        ft_drdy = 1'b0;
        @(negedge clk);
        check({tag, "/drdy_after"}, 64'(lpp_drdy), 64'd1);
        check({tag, "/srdy_after"}, 64'(ft_srdy), 64'd0);
    endtask

    logic [47:0]   pool [6];
    logic [47:0]   r_src, r_dst;
    logic [PS-1:0] r_sp;

    initial begin
        reset    = 1'b1;
        lpp_srdy = 1'b0;
        lpp_data = '0;
        ft_drdy  = 1'b0;
        flush    = 1'b0;
        model_clear();
        #1;
        check("rst_drdy", 64'(lpp_drdy), 64'd1);
        check("rst_srdy", 64'(ft_srdy), 64'd0);
        check("rst_data", 64'(ft_data), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        send("learn1",  48'h1, 48'h2, 2'd1, 4'b1101, 0, 1'b0);
        send("hit",     48'h2, 48'h1, 2'd3, 4'b0010, 0, 1'b0);
        send("filter",  48'h5, 48'h1, 2'd1, 4'b0000, 0, 1'b0);
        send("bcast",   48'h6, 48'hFFFF_FFFF_FFFF, 2'd0, 4'b1110, 0, 1'b0);
        // Multicast source hashing onto the entry holding MAC 1 must not disturb it.
        send("mc_src",  48'h0100_0000_0000, 48'h9, 2'd2, 4'b1011, 0, 1'b0);
        send("mc_keep", 48'hA, 48'h1, 2'd0, 4'b0010, 5, 1'b0);

        send("coll_a",  48'h3,  48'h7, 2'd1, 4'b1101, 0, 1'b0);
        send("coll_b",  48'h30, 48'h7, 2'd2, 4'b1011, 0, 1'b0);
        send("coll_lk", 48'hE,  48'h3, 2'd0, 4'b1110, 0, 1'b0);
        send("flush_ln", 48'hD, 48'h30, 2'd3, 4'b0100, 0, 1'b1);
        send("post_fl", 48'hC,  48'hD, 2'd0, 4'b1110, 0, 1'b0);

        send("relearn", 48'h1, 48'h2, 2'd1, 4'b1101, 0, 1'b0);
        @(negedge clk);
        lpp_data = {2'd0, 48'h1, 48'hC};
        lpp_srdy = 1'b1;
        @(posedge clk);
        #1;
        lpp_srdy = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_drdy", 64'(lpp_drdy), 64'd1);
        check("mid_rst_data", 64'(ft_data), 64'd0);
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_nosrdy", 64'(ft_srdy), 64'd0);
        end
        send("post_rst", 48'hB, 48'h1, 2'd0, 4'b1110, 0, 1'b0);

        pool[0] = 48'h3;
        pool[1] = 48'h30;
        pool[2] = 48'hA5A5_0000_1234;
        pool[3] = 48'h0000_00BE_EF00;
        pool[4] = 48'h1;
        pool[5] = 48'hFEDC_BA98_7654;
        for (int i = 0; i < 30; i++) begin
            r_src = pool[$urandom_range(0, 5)];
            r_dst = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) r_src = r_src | 48'h0100_0000_0000;
            if ($urandom_range(0, 7) == 0) r_dst = r_dst | 48'h0100_0000_0000;
            r_sp = PS'($urandom_range(0, 3));
            send("rand", r_src, r_dst, r_sp, ref_mask(r_dst, r_sp), $urandom_range(0, 2), 1'b0);
        end

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
